debounce_bank: RTL and testbench
================================

// Module: debounce_bank
// PURPOSE
//  N-channel button conditioner: per-channel 2-flop synchroniser, symmetric press/release debounce, long-press and auto-repeat.
//  Replaces single-button debounce in the clock UI; feeds set/mode/up/down events to the time-keeping FSMs.
//  One shared ms-tick prescaler serves all channels.
//  Unlike the first-generation debouncer, a press is reported only after the input is stable, so glitches are rejected.
// PARAMETERS
//  N_CH          4        number of button channels
//  TICK_CYCLES   100000   ck cycles per debounce tick (1 ms at 100 MHz); must be >= 2
//  DEB_TICKS     10       consecutive stable ticks needed to accept a press or a release; must be >= 1
//  LONG_TICKS    1000     ticks held, counted after press is accepted, before btn_long; 0 disables long and repeat
//  REPEAT_TICKS  200      tick period of btn_repeat while in LONG; 0 disables repeat
// PORTS
//  ck           in   1     system clock; all logic on its rising edge
//  reset        in   1     synchronous, active-high reset
//  button       in   N_CH  raw asynchronous button inputs, 1 = pressed
//  tick         out  1     one-cycle pulse every TICK_CYCLES cycles (exported for other timers)
//  btn_level    out  N_CH  debounced level
//  btn_press    out  N_CH  one-cycle pulse on accepted press
//  btn_release  out  N_CH  one-cycle pulse on accepted release
//  btn_long     out  N_CH  one-cycle pulse when hold reaches LONG_TICKS
//  btn_repeat   out  N_CH  one-cycle pulse every REPEAT_TICKS while in LONG
// BEHAVIOUR
//  Reset
//   - Synchronous; sync flops, prescaler, counters and every output = 0; every channel -> IDLE.
//   - Overrides all events in the same cycle; no release pulse is generated by a reset.
//  Prescaler
//   - Counts 0..TICK_CYCLES-1; tick = 1 in the cycle the count equals TICK_CYCLES-1, then the count wraps to 0.
//   - First tick after reset is at cycle TICK_CYCLES-1.
//  Synchroniser
//   - s = button delayed 2 cycles; the FSM sees only s.
//  Per-channel FSM (registered state); cnt = per-channel tick counter, cleared on every state change
//   - IDLE: s=1 -> PRESS_WAIT.
//   - PRESS_WAIT: s=0 in any cycle -> IDLE (glitch rejected, no outputs).
//     On tick with s=1: cnt++; when cnt reaches DEB_TICKS -> HELD.
//   - HELD: s=0 -> RELEASE_WAIT.
//     On tick: cnt++; if LONG_TICKS!=0 and cnt reaches LONG_TICKS -> LONG.
//   - LONG: s=0 -> RELEASE_WAIT.
//     On tick: cnt++; if REPEAT_TICKS!=0 and cnt reaches REPEAT_TICKS -> btn_repeat pulse and cnt := 0.
//   - RELEASE_WAIT: s=1 -> rcnt := 0, stay in RELEASE_WAIT (release bounce absorbed).
//     On tick with s=0: rcnt++; when rcnt reaches DEB_TICKS -> IDLE.
//     Long/repeat timing frozen; no long or repeat pulses here.
//  Outputs
//   - Registered; pulses coincide with the first cycle of the new state.
//   - btn_press on entering HELD; btn_long on entering LONG; btn_release on RELEASE_WAIT -> IDLE.
//   - btn_level = 1 in HELD, LONG and RELEASE_WAIT; 0 in IDLE and PRESS_WAIT.
//   - Each pulse is exactly 1 cycle; at most one pulse type per channel per cycle.
//  Latency and widths
//   - Press latency from button edge: 2 sync cycles + between (DEB_TICKS-1)*TICK_CYCLES+1 and DEB_TICKS*TICK_CYCLES cycles.
//   - cnt width = $clog2(max(DEB_TICKS, LONG_TICKS, REPEAT_TICKS)+1); no wrap is possible.
//  Simultaneous events
//   - Tick and s-change in the same cycle: the s-change transition wins and the tick is not counted.
//   - Channels are fully independent; simultaneous presses give same-cycle pulses.
// STRUCTURE
//  - debounce_defs.vh (shared include): localparam state encodings IDLE=0, PRESS_WAIT=1, HELD=2, LONG=3, RELEASE_WAIT=4 (3 bits).
//  - Sub-module debounce_channel: sync flops, FSM, cnt and pulse outputs for one channel.
//    Instantiated N_CH times in a generate loop.
//  - Prescaler lives in debounce_bank.
// TESTING (N_CH=2, TICK_CYCLES=4, DEB_TICKS=3, LONG_TICKS=8, REPEAT_TICKS=4)
//  1. button[0] high 6 cycles then low -> no btn_press, btn_level[0] stays 0, FSM back in IDLE.
//  2. button[0] held 60 cycles -> btn_press once after 2+9..12 cycles; btn_long 32 cycles after press;
//     btn_repeat every 16 cycles after that.
//  3. Release with bounce: low 5 cycles, high 3, low 20 -> btn_level stays 1 through bounce;
//     single btn_release about 12 cycles after last fall.
//  4. button=2'b11 same cycle -> btn_press=2'b11 in one cycle; channel 1 released early, channel 0 unaffected.
//  5. reset pulse while channel 0 in LONG, button still high -> all outputs 0 next cycle, no release pulse;
//     fresh btn_press after re-debounce.
//  6. REPEAT_TICKS=0, then LONG_TICKS=0 -> no repeat, then no long, during 100-cycle hold; tick period exactly 4 cycles.

Source files
------------

// File: rtl/debounce_bank_pkg.sv
// -----------------------------------------------------------------------------
// debounce_bank_pkg
// Shared definitions for the button-conditioner bank: the per-channel state
// encoding and a helper that sizes the per-channel tick counter.
// No ports (package).
// -----------------------------------------------------------------------------
package debounce_bank_pkg;

  // Channel states; the numeric values are fixed so that debug probes and the
  // time-keeping FSM documentation agree on the encoding.
  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_PRESS_WAIT   = 3'd1,
    ST_HELD         = 3'd2,
    ST_LONG         = 3'd3,
    ST_RELEASE_WAIT = 3'd4
  } deb_state_e;

  // Largest of the three tick targets; the counter must be able to hold it.
  function automatic int unsigned max3_u(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
    int unsigned m_ab;
    m_ab = (a > b) ? a : b;
    return (m_ab > c) ? m_ab : c;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
// One button channel: 2-flop synchroniser, press/release debounce FSM,
// long-press detection and auto-repeat. All outputs are registered and the
// pulses line up with the first cycle of the state they announce.
// Ports:
//   i_ck        system clock (rising edge)
//   i_reset     synchronous active-high reset
//   i_button    raw asynchronous button, 1 = pressed
//   i_tick      one-cycle debounce tick from the shared prescaler
//   o_level     debounced level (1 in HELD, LONG, RELEASE_WAIT)
//   o_press     pulse on accepted press
//   o_release   pulse on accepted release
//   o_long      pulse when the hold reaches LONG_TICKS
//   o_repeat    pulse every REPEAT_TICKS while in LONG
// -----------------------------------------------------------------------------
module debounce_channel
  import debounce_bank_pkg::*;
#(
  parameter int unsigned DEB_TICKS    = 10,
  parameter int unsigned LONG_TICKS   = 1000,
  parameter int unsigned REPEAT_TICKS = 200
) (
  input  logic i_ck,
  input  logic i_reset,
  input  logic i_button,
  input  logic i_tick,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_long,
  output logic o_repeat
);

  localparam int unsigned CNT_MAX = max3_u(DEB_TICKS, LONG_TICKS, REPEAT_TICKS);
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] DEB_C    = CW'(DEB_TICKS);
  localparam logic [CW-1:0] LONG_C   = CW'(LONG_TICKS);
  localparam logic [CW-1:0] REPEAT_C = CW'(REPEAT_TICKS);

  // With long disabled the LONG state is unreachable, so repeat is moot too.
  localparam bit LONG_EN   = (LONG_TICKS != 0);
  localparam bit REPEAT_EN = (REPEAT_TICKS != 0) && (LONG_TICKS != 0);

  logic          r_sync1;
  logic          r_sync2;
  deb_state_e    r_state;
  deb_state_e    w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [CW-1:0] w_cnt_inc;
  logic          w_press_nxt;
  logic          w_release_nxt;
  logic          w_long_nxt;
  logic          w_repeat_nxt;
  logic          w_level_nxt;
  logic          r_level;
  logic          r_press;
  logic          r_release;
  logic          r_long;
  logic          r_repeat;

  // Two-flop synchroniser for the asynchronous button input.
  always_ff @(posedge i_ck) begin
    if (i_reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_button;
      r_sync2 <= r_sync1;
    end
  end

  // Cannot wrap: the counter is cleared before it exceeds its target.
  assign w_cnt_inc = r_cnt + CW'(1);

  // Next-state, counter and pulse decode. A level change of the synchronised
  // button always takes priority over a tick arriving in the same cycle.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_press_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    w_long_nxt    = 1'b0;
    w_repeat_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_sync2) begin
          w_state_nxt = ST_PRESS_WAIT;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = '0;
        end
      end
      ST_PRESS_WAIT: begin
        if (!r_sync2) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else if (i_tick) begin
          if (w_cnt_inc == DEB_C) begin
            w_state_nxt = ST_HELD;
            w_cnt_nxt   = '0;
            w_press_nxt = 1'b1;
          end else begin
            w_cnt_nxt   = w_cnt_inc;
          end
        end else begin
          w_cnt_nxt   = r_cnt;
        end
      end
      ST_HELD: begin
        if (!r_sync2) begin
          w_state_nxt = ST_RELEASE_WAIT;
          w_cnt_nxt   = '0;
        end else if (i_tick && LONG_EN) begin
          if (w_cnt_inc == LONG_C) begin
            w_state_nxt = ST_LONG;
            w_cnt_nxt   = '0;
            w_long_nxt  = 1'b1;
          end else begin
            w_cnt_nxt   = w_cnt_inc;
          end
        end else begin
          w_cnt_nxt   = r_cnt;
        end
      end
      ST_LONG: begin
        if (!r_sync2) begin
          w_state_nxt = ST_RELEASE_WAIT;
          w_cnt_nxt   = '0;
        end else if (i_tick && REPEAT_EN) begin
          if (w_cnt_inc == REPEAT_C) begin
            w_cnt_nxt    = '0;
            w_repeat_nxt = 1'b1;
          end else begin
            w_cnt_nxt    = w_cnt_inc;
          end
        end else begin
          w_cnt_nxt   = r_cnt;
        end
      end
      ST_RELEASE_WAIT: begin
        // Any bounce back to pressed restarts the release qualification.
        if (r_sync2) begin
          w_cnt_nxt = '0;
        end else if (i_tick) begin
          if (w_cnt_inc == DEB_C) begin
            w_state_nxt   = ST_IDLE;
            w_cnt_nxt     = '0;
            w_release_nxt = 1'b1;
          end else begin
            w_cnt_nxt     = w_cnt_inc;
          end
        end else begin
          w_cnt_nxt = r_cnt;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign w_level_nxt = (w_state_nxt == ST_HELD) || (w_state_nxt == ST_LONG) ||
                       (w_state_nxt == ST_RELEASE_WAIT);

  // State, counter and registered outputs; reset suppresses every pulse.
  always_ff @(posedge i_ck) begin
    if (i_reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_long    <= 1'b0;
      r_repeat  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_level   <= w_level_nxt;
      r_press   <= w_press_nxt;
      r_release <= w_release_nxt;
      r_long    <= w_long_nxt;
      r_repeat  <= w_repeat_nxt;
    end
  end

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;
  assign o_long    = r_long;
  assign o_repeat  = r_repeat;

endmodule

// File: rtl/debounce_bank.sv
// -----------------------------------------------------------------------------
// debounce_bank
// N-channel button conditioner for the clock UI. One shared prescaler makes
// the debounce tick; each channel is an independent debounce_channel.
// Ports:
//   ck           system clock (rising edge)
//   reset        synchronous active-high reset
//   button       raw asynchronous buttons, 1 = pressed
//   tick         one-cycle pulse every TICK_CYCLES cycles
//   btn_level    debounced levels
//   btn_press    one-cycle pulse per accepted press
//   btn_release  one-cycle pulse per accepted release
//   btn_long     one-cycle pulse when a hold reaches LONG_TICKS
//   btn_repeat   one-cycle pulse every REPEAT_TICKS while in long-press
// -----------------------------------------------------------------------------
module debounce_bank
  import debounce_bank_pkg::*;
#(
  parameter int unsigned N_CH         = 4,
  parameter int unsigned TICK_CYCLES  = 100000,
  parameter int unsigned DEB_TICKS    = 10,
  parameter int unsigned LONG_TICKS   = 1000,
  parameter int unsigned REPEAT_TICKS = 200
) (
  input  logic            ck,
  input  logic            reset,
  input  logic [N_CH-1:0] button,
  output logic            tick,
  output logic [N_CH-1:0] btn_level,
  output logic [N_CH-1:0] btn_press,
  output logic [N_CH-1:0] btn_release,
  output logic [N_CH-1:0] btn_long,
  output logic [N_CH-1:0] btn_repeat
);

  localparam int unsigned PW = $clog2(TICK_CYCLES);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_CYCLES - 1);
  // tick is registered, so it is armed one count early to land on PRE_LAST.
  localparam logic [PW-1:0] PRE_ARM  = PW'(TICK_CYCLES - 2);

  logic [PW-1:0] r_pre;
  logic          r_tick;

  // Shared prescaler: counts 0..TICK_CYCLES-1, tick high while at the top.
  always_ff @(posedge ck) begin
    if (reset) begin
      r_pre  <= '0;
      r_tick <= 1'b0;
    end else begin
      if (r_pre == PRE_LAST) begin
        r_pre <= '0;
      end else begin
        r_pre <= r_pre + PW'(1);
      end
      r_tick <= (r_pre == PRE_ARM);
    end
  end

  assign tick = r_tick;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    debounce_channel #(
      .DEB_TICKS    (DEB_TICKS),
      .LONG_TICKS   (LONG_TICKS),
      .REPEAT_TICKS (REPEAT_TICKS)
    ) u_ch (
      .i_ck      (ck),
      .i_reset   (reset),
      .i_button  (button[g]),
      .i_tick    (r_tick),
      .o_level   (btn_level[g]),
      .o_press   (btn_press[g]),
      .o_release (btn_release[g]),
      .o_long    (btn_long[g]),
      .o_repeat  (btn_repeat[g])
    );
  end

endmodule

// File: tb/tb_debounce_bank.sv
// -----------------------------------------------------------------------------
// tb_debounce_bank
// Three bank instances (N_CH=2, TICK_CYCLES=4, DEB_TICKS=3):
//   u_a  LONG_TICKS=8 REPEAT_TICKS=4   main behaviour
//   u_b  LONG_TICKS=8 REPEAT_TICKS=0   repeat disabled
//   u_c  LONG_TICKS=0 REPEAT_TICKS=4   long disabled
// Expected pulses (hand-computed cycle numbers) are queued by the stimulus;
// a monitor pops and compares every pulse the DUTs produce.
// Cycle n = the interval after the n-th rising clock edge.
// -----------------------------------------------------------------------------
module tb_debounce_bank;

  localparam int K_PRESS   = 0;
  localparam int K_RELEASE = 1;
  localparam int K_LONG    = 2;
  localparam int K_REPEAT  = 3;

  typedef struct {
    int cyc;
    int inst;
    int kind;
    int ch;
  } ev_t;

  logic       ck = 1'b0;
  logic       reset;
  logic [1:0] btn_a, btn_b, btn_c;
  logic       tick_a, tick_b, tick_c;
  logic [1:0] lvl_a, prs_a, rel_a, lng_a, rpt_a;
  logic [1:0] lvl_b, prs_b, rel_b, lng_b, rpt_b;
  logic [1:0] lvl_c, prs_c, rel_c, lng_c, rpt_c;

  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;
  int  last_rst_cyc = 0;
  int  last_tick = -1;
  ev_t exp_q[$];
  logic [1:0] p [3][4];

  always #5 ck = ~ck;

  always @(posedge ck) begin
    cyc <= cyc + 1;
    if (reset) last_rst_cyc <= cyc + 1;
  end

  debounce_bank #(.N_CH(2), .TICK_CYCLES(4), .DEB_TICKS(3), .LONG_TICKS(8), .REPEAT_TICKS(4)) u_a (
    .ck(ck), .reset(reset), .button(btn_a), .tick(tick_a), .btn_level(lvl_a),
    .btn_press(prs_a), .btn_release(rel_a), .btn_long(lng_a), .btn_repeat(rpt_a));

  debounce_bank #(.N_CH(2), .TICK_CYCLES(4), .DEB_TICKS(3), .LONG_TICKS(8), .REPEAT_TICKS(0)) u_b (
    .ck(ck), .reset(reset), .button(btn_b), .tick(tick_b), .btn_level(lvl_b),
    .btn_press(prs_b), .btn_release(rel_b), .btn_long(lng_b), .btn_repeat(rpt_b));

  debounce_bank #(.N_CH(2), .TICK_CYCLES(4), .DEB_TICKS(3), .LONG_TICKS(0), .REPEAT_TICKS(4)) u_c (
    .ck(ck), .reset(reset), .button(btn_c), .tick(tick_c), .btn_level(lvl_c),
    .btn_press(prs_c), .btn_release(rel_c), .btn_long(lng_c), .btn_repeat(rpt_c));

  task automatic at(input int n);
    while (cyc < n) @(negedge ck);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic expect_ev(input int c, input int inst, input int kind, input int ch);
    ev_t e;
    e.cyc = c; e.inst = inst; e.kind = kind; e.ch = ch;
    exp_q.push_back(e);
  endtask

  // Monitor: pulses, tick schedule and tick agreement across instances.
  initial begin
    ev_t e;
    forever begin
      @(negedge ck);
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        checks++;
        errors++;
        $display("FAIL missing pulse inst=%0d kind=%0d ch=%0d: not seen, required at cycle %0d",
                 e.inst, e.kind, e.ch, e.cyc);
      end
      p[0][0] = prs_a; p[0][1] = rel_a; p[0][2] = lng_a; p[0][3] = rpt_a;
      p[1][0] = prs_b; p[1][1] = rel_b; p[1][2] = lng_b; p[1][3] = rpt_b;
      p[2][0] = prs_c; p[2][1] = rel_c; p[2][2] = lng_c; p[2][3] = rpt_c;
      for (int i = 0; i < 3; i++) begin
        for (int k = 0; k < 4; k++) begin
          for (int c = 0; c < 2; c++) begin
            if (p[i][k][c] === 1'b1) begin
              checks++;
              if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected pulse: got inst=%0d kind=%0d ch=%0d at cycle %0d, required none",
                         i, k, c, cyc);
              end else begin
                e = exp_q.pop_front();
                if (e.inst != i || e.kind != k || e.ch != c || e.cyc != cyc) begin
                  errors++;
                  $display("FAIL pulse: got inst=%0d kind=%0d ch=%0d cycle=%0d, required inst=%0d kind=%0d ch=%0d cycle=%0d",
                           i, k, c, cyc, e.inst, e.kind, e.ch, e.cyc);
                end
              end
            end
          end
        end
      end
      if (tick_a === 1'b1) begin
        int req;
        req = (last_tick > last_rst_cyc) ? last_tick + 4 : last_rst_cyc + 3;
        chk("tick_schedule", cyc, req);
        last_tick = cyc;
      end
      if (tick_b !== tick_a || tick_c !== tick_a) begin
        chk("tick_agree", {tick_b, tick_c}, {tick_a, tick_a});
      end
    end
  end

  // Directed stimulus with hand-computed expectations.
  initial begin
    reset = 1'b1;
    btn_a = 2'b00; btn_b = 2'b00; btn_c = 2'b00;
    at(2); reset = 1'b0;
    at(3); chk("reset_outputs", {tick_a, lvl_a, prs_a, rel_a, lng_a, rpt_a}, 32'd0);
    at(4); chk("no_tick_before_first", tick_a, 1'b0);
    at(5); chk("first_tick", tick_a, 1'b1);

    // Glitch: 6 cycles high never reaches 3 ticks.
    at(10); btn_a[0] = 1'b1;
    at(15); chk("glitch_level_mid", lvl_a, 2'b00);
    at(16); btn_a[0] = 1'b0;
    at(22); chk("glitch_level_after", lvl_a, 2'b00);

    // Long hold: press, long, one repeat.
    at(30); btn_a[0] = 1'b1;
    expect_ev(42, 0, K_PRESS, 0);
    expect_ev(74, 0, K_LONG, 0);
    expect_ev(90, 0, K_REPEAT, 0);
    at(41); chk("level_before_press", lvl_a, 2'b00);
    at(42); chk("level_at_press", lvl_a, 2'b01);

    // Release with bounce.
    at(90); btn_a[0] = 1'b0;
    expect_ev(110, 0, K_RELEASE, 0);
    at(95); btn_a[0] = 1'b1; chk("level_in_bounce", lvl_a, 2'b01);
    at(98); btn_a[0] = 1'b0;
    at(109); chk("level_before_release", lvl_a, 2'b01);
    at(110); chk("level_at_release", lvl_a, 2'b00);

    // Simultaneous presses, channel 1 released early.
    at(120); btn_a = 2'b11;
    expect_ev(134, 0, K_PRESS, 0);
    expect_ev(134, 0, K_PRESS, 1);
    expect_ev(154, 0, K_RELEASE, 1);
    expect_ev(166, 0, K_LONG, 0);
    at(134); chk("level_both", lvl_a, 2'b11);
    at(140); btn_a[1] = 1'b0;
    at(154); chk("level_ch1_released", lvl_a, 2'b01);

    // Reset during LONG with button still held.
    at(170); reset = 1'b1;
    at(171); reset = 1'b0;
    chk("reset_in_long", {tick_a, lvl_a, prs_a, rel_a, lng_a, rpt_a}, 32'd0);
    expect_ev(183, 0, K_PRESS, 0);
    at(174); chk("first_tick_after_reset", tick_a, 1'b1);
    at(182); chk("level_before_repress", lvl_a, 2'b00);
    at(183); chk("level_repress", lvl_a, 2'b01);
    at(190); btn_a[0] = 1'b0;
    expect_ev(203, 0, K_RELEASE, 0);

    // Repeat disabled (u_b) and long disabled (u_c), 100-cycle hold.
    at(210); btn_b[0] = 1'b1; btn_c[0] = 1'b1;
    expect_ev(223, 1, K_PRESS, 0);
    expect_ev(223, 2, K_PRESS, 0);
    expect_ev(255, 1, K_LONG, 0);
    at(300); chk("levels_hold_bc", {lvl_b, lvl_c}, 4'b0101);
    at(310); btn_b[0] = 1'b0; btn_c[0] = 1'b0;
    expect_ev(323, 1, K_RELEASE, 0);
    expect_ev(323, 2, K_RELEASE, 0);
    at(330); chk("levels_released_bc", {lvl_b, lvl_c}, 4'b0000);

    at(340);
    chk("pending_expectations", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
